// File: rtl/csa_pipelined_adder_if.sv
// Operand/result handshake bundle for csa_pipelined_adder.
// master drives operands and out_ready; slave is the adder.
interface csa_pipelined_adder_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] input1;
   logic [WIDTH-1:0] input2;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             overflow;

   modport master (
      output in_valid, input1, input2, cin, sub, out_ready,
      input  in_ready, out_valid, result, cout, overflow
   );

   modport slave (
      input  in_valid, input1, input2, cin, sub, out_ready,
      output in_ready, out_valid, result, cout, overflow
   );
endinterface

// File: rtl/csa_pipelined_adder.sv
// Pipelined carry-select add/sub: one SEG_WIDTH segment resolved per clock,
// valid/ready on both sides, whole pipe stalls together under backpressure.
module csa_pipelined_adder #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned SEG_WIDTH = 8,
   parameter int unsigned BLOCK     = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   csa_pipelined_adder_if.slave bus
);

   localparam int unsigned STAGES = WIDTH / SEG_WIDTH;
   localparam int unsigned NBLK   = SEG_WIDTH / BLOCK;

   if ((WIDTH % SEG_WIDTH) != 0 || (SEG_WIDTH % BLOCK) != 0) begin : g_bad_params
      $error("csa_pipelined_adder: WIDTH must be a multiple of SEG_WIDTH and SEG_WIDTH of BLOCK");
   end

   // Returns {carry into segment MSB, carry out, sum}; each block ripples both
   // carry hypotheses and the real block carry picks one.
   function automatic logic [SEG_WIDTH+1:0] cs_add(
      input logic [SEG_WIDTH-1:0] a,
      input logic [SEG_WIDTH-1:0] b,
      input logic                 c
   );
      logic [SEG_WIDTH-1:0] s;
      logic [BLOCK-1:0]     s0;
      logic [BLOCK-1:0]     s1;
      logic                 carry;
      logic                 c_top;
      logic                 k0;
      logic                 k1;
      logic                 t0;
      logic                 t1;
      logic                 ai;
      logic                 bi;
      s     = '0;
      s0    = '0;
      s1    = '0;
      carry = c;
      c_top = c;
      for (int unsigned j = 0; j < NBLK; j++) begin
         k0 = 1'b0;
         k1 = 1'b1;
         t0 = 1'b0;
         t1 = 1'b1;
         for (int unsigned i = 0; i < BLOCK; i++) begin
            ai    = a[j*BLOCK+i];
            bi    = b[j*BLOCK+i];
            t0    = k0;
            t1    = k1;
            s0[i] = ai ^ bi ^ k0;
            s1[i] = ai ^ bi ^ k1;
            k0    = (ai & bi) | (k0 & (ai ^ bi));
            k1    = (ai & bi) | (k1 & (ai ^ bi));
         end
         s[j*BLOCK +: BLOCK] = carry ? s1 : s0;
         c_top = carry ? t1 : t0;
         carry = carry ? k1 : k0;
      end
      return {c_top, carry, s};
   endfunction

   logic             w_adv;
   logic [WIDTH-1:0] w_b_cond;
   logic             w_c_cond;

   logic             r_out_valid;
   logic [WIDTH-1:0] r_result;
   logic             r_cout;
   logic             r_overflow;

   assign w_adv         = !r_out_valid || bus.out_ready;
   assign w_b_cond      = bus.sub ? ~bus.input2 : bus.input2;
   assign w_c_cond      = bus.sub ^ bus.cin;

   assign bus.in_ready  = w_adv;
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
   assign bus.cout      = r_cout;
   assign bus.overflow  = r_overflow;

   // Stage k keeps the resolved low bits plus the still-unused high operand slices.
   genvar k;
   for (k = 0; k < STAGES - 1; k++) begin : g_mid
      localparam int unsigned AW = WIDTH - k * SEG_WIDTH;
      localparam int unsigned SW = (k + 1) * SEG_WIDTH;

      logic [AW-1:0]           w_a;
      logic [AW-1:0]           w_b;
      logic                    w_c;
      logic                    w_v;
      logic [SEG_WIDTH:0]      w_add;
      logic [SW-1:0]           w_sum;

      logic                    r_v;
      logic                    r_carry;
      logic [AW-SEG_WIDTH-1:0] r_ahi;
      logic [AW-SEG_WIDTH-1:0] r_bhi;
      logic [SW-1:0]           r_sum;

      if (k == 0) begin : g_src
         assign w_a   = bus.input1;
         assign w_b   = w_b_cond;
         assign w_c   = w_c_cond;
         assign w_v   = bus.in_valid;
         assign w_sum = w_add[SEG_WIDTH-1:0];
      end else begin : g_src
         assign w_a   = g_mid[k-1].r_ahi;
         assign w_b   = g_mid[k-1].r_bhi;
         assign w_c   = g_mid[k-1].r_carry;
         assign w_v   = g_mid[k-1].r_v;
         assign w_sum = {w_add[SEG_WIDTH-1:0], g_mid[k-1].r_sum};
      end

      assign w_add = (SEG_WIDTH + 1)'(cs_add(w_a[SEG_WIDTH-1:0], w_b[SEG_WIDTH-1:0], w_c));

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_v     <= 1'b0;
            r_carry <= 1'b0;
            r_ahi   <= '0;
            r_bhi   <= '0;
            r_sum   <= '0;
         end else if (w_adv) begin
            r_v     <= w_v;
            r_carry <= w_add[SEG_WIDTH];
            r_ahi   <= w_a[AW-1:SEG_WIDTH];
            r_bhi   <= w_b[AW-1:SEG_WIDTH];
            r_sum   <= w_sum;
         end
      end
   end

   logic [SEG_WIDTH-1:0] w_la;
   logic [SEG_WIDTH-1:0] w_lb;
   logic                 w_lc;
   logic                 w_lv;
   logic [SEG_WIDTH+1:0] w_ladd;
   logic [WIDTH-1:0]     w_lres;

   if (STAGES == 1) begin : g_last_src
      assign w_la   = bus.input1[SEG_WIDTH-1:0];
      assign w_lb   = w_b_cond[SEG_WIDTH-1:0];
      assign w_lc   = w_c_cond;
      assign w_lv   = bus.in_valid;
      assign w_lres = w_ladd[SEG_WIDTH-1:0];
   end else begin : g_last_src
      assign w_la   = g_mid[STAGES-2].r_ahi;
      assign w_lb   = g_mid[STAGES-2].r_bhi;
      assign w_lc   = g_mid[STAGES-2].r_carry;
      assign w_lv   = g_mid[STAGES-2].r_v;
      assign w_lres = {w_ladd[SEG_WIDTH-1:0], g_mid[STAGES-2].r_sum};
   end

   assign w_ladd = cs_add(w_la, w_lb, w_lc);

   // The final segment doubles as the output register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_cout      <= 1'b0;
         r_overflow  <= 1'b0;
      end else if (w_adv) begin
         r_out_valid <= w_lv;
         r_result    <= w_lres;
         r_cout      <= w_ladd[SEG_WIDTH];
         r_overflow  <= w_ladd[SEG_WIDTH+1] ^ w_ladd[SEG_WIDTH];
      end
   end

endmodule
